// File: rtl/i2c_target_sync.sv
// i2c_target_sync
// Clocked I2C target (responder). SCL/SDA are oversampled on clk, START/STOP
// are detected from synchronized edges, the target ACKs TARGET_ADDR and
// streams bytes between the bus and a simple byte interface.
//
// Ports:
//   clk       system clock, at least 8x the SCL frequency
//   rst       asynchronous active-high reset
//   scl_in    SCL bus level (never stretched by this target)
//   sda_in    SDA bus level
//   sda_oe    1 = pull SDA low (open drain), 0 = release
//   rx_data   last byte written by the controller
//   rx_valid  one-cycle pulse when rx_data is updated
//   tx_data   byte returned on the next read byte
//   tx_req    one-cycle pulse when tx_data is sampled into the shift register
//   busy      high from an addressed START until STOP (or address mismatch)
//   state_dbg current FSM state, for observation only
//
// Handshake: rx_valid and tx_req are single-cycle strobes with no
// backpressure. rx_data is valid in the rx_valid cycle and holds until the
// next written byte; tx_data must be stable in the cycle tx_req is high.
module i2c_target_sync #(
  parameter logic [6:0] TARGET_ADDR = 7'b1010101,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  // Synchronizers plus one history flop; preset to 1 so reset looks like an
  // idle bus and produces no spurious edges.
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, sda_rise, sda_fall;
  logic                   start_det, stop_det;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign sda_rise  = sda_s & ~sda_d;
  assign sda_fall  = ~sda_s & sda_d;
  // SCL must be high both now and in the previous cycle, so an SDA edge that
  // coincides with an SCL edge is never taken as START/STOP.
  assign start_det = sda_fall & scl_s & scl_d;
  assign stop_det  = sda_rise & scl_s & scl_d;

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [6:0] shreg, shreg_n;   // first 7 bits of the byte being received
  logic [6:0] tx_sh, tx_sh_n;   // bits still to be driven after the current one
  logic       rw, rw_n;
  logic       mack, mack_n;     // controller ACKed the last read byte
  logic       sda_oe_n;
  logic [7:0] rx_data_n;
  logic       rx_valid_n, tx_req_n, busy_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shreg    <= 7'd0;
      tx_sh    <= 7'd0;
      rw       <= 1'b0;
      mack     <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      tx_sh    <= tx_sh_n;
      rw       <= rw_n;
      mack     <= mack_n;
      sda_oe   <= sda_oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_req   <= tx_req_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    tx_sh_n    = tx_sh;
    rw_n       = rw;
    mack_n     = mack;
    sda_oe_n   = sda_oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    busy_n     = busy;

    if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = 3'd0;
      sda_oe_n  = 1'b0;
      mack_n    = 1'b0;
    end else if (stop_det) begin
      state_n   = IDLE;
      bit_cnt_n = 3'd0;
      sda_oe_n  = 1'b0;
      mack_n    = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state)
        IDLE: ;

        ADDR: begin
          if (scl_rise) begin
            shreg_n   = {shreg[5:0], sda_s};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              // shreg holds the 7 address bits, sda_s is R/W
              if (shreg == TARGET_ADDR) begin
                rw_n    = sda_s;
                busy_n  = 1'b1;
                state_n = ADDR_ACK;
              end else begin
                busy_n  = 1'b0;
                state_n = IGNORE;
              end
            end
          end
        end

        // sda_oe doubles as the phase flag: low = waiting for the fall that
        // ends bit 8, high = holding the ACK slot.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else if (rw) begin
              tx_sh_n   = tx_data[6:0];
              tx_req_n  = 1'b1;
              sda_oe_n  = ~tx_data[7];
              bit_cnt_n = 3'd0;
              state_n   = RD_DATA;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 3'd0;
              state_n   = WR_DATA;
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            shreg_n   = {shreg[5:0], sda_s};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_n  = {shreg, sda_s};
              rx_valid_n = 1'b1;
              state_n    = WR_ACK;
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 3'd0;
              state_n   = WR_DATA;
            end
          end
        end

        // bit_cnt counts falls since bit 7 was put on the bus; the eighth
        // fall ends the last data bit and releases SDA for the controller.
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 3'd0;
              mack_n    = 1'b0;
              state_n   = RD_ACK;
            end else begin
              sda_oe_n  = ~tx_sh[6];
              tx_sh_n   = {tx_sh[5:0], 1'b0};
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              sda_oe_n = 1'b0;
              state_n  = IGNORE;
            end else begin
              mack_n = 1'b1;
            end
          end else if (scl_fall && mack) begin
            tx_sh_n   = tx_data[6:0];
            tx_req_n  = 1'b1;
            sda_oe_n  = ~tx_data[7];
            bit_cnt_n = 3'd0;
            mack_n    = 1'b0;
            state_n   = RD_DATA;
          end
        end

        IGNORE: sda_oe_n = 1'b0;

        default: state_n = IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_i2c_target_sync.sv
// tb_i2c_target_sync
// Drives I2C controller traffic into i2c_target_sync through a wired-AND SDA
// model. Written bytes are pushed into an expected queue and checked by a
// monitor on rx_valid; tx_data is supplied from a queue advanced on tx_req.
module tb_i2c_target_sync;

  localparam int Q = 4;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_ctl;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_req_cnt = 0;
  logic oe_seen = 1'b0;

  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_next_q[$];

  assign sda_bus = sda_ctl & ~sda_oe;

  i2c_target_sync dut (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor for written bytes
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      if (rx_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got rx_data %0h, expected no rx_valid", rx_data);
      end else begin
        check("rx_data", {24'd0, rx_data}, {24'd0, rx_exp_q.pop_front()});
      end
    end
  end

  // tx byte supplier and sda_oe observer
  always @(negedge clk) begin
    if (!rst && tx_req) begin
      tx_req_cnt++;
      if (tx_next_q.size() != 0) tx_data = tx_next_q.pop_front();
    end
    if (sda_oe) oe_seen = 1'b1;
  end

  // driver tasks
  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    wq(); sda_ctl = 1'b1;
    wq(); scl = 1'b1;
    wq(); sda_ctl = 1'b0;
    wq(); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wq(); sda_ctl = 1'b0;
    wq(); scl = 1'b1;
    wq(); sda_ctl = 1'b1;
    wq();
  endtask

  task automatic bus_bit(input logic b, output logic r);
    wq(); sda_ctl = b;
    wq(); scl = 1'b1;
    wq(); r = sda_bus;
    wq(); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
    bus_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      d[i] = r;
    end
    bus_bit(~ack, r);
  endtask

  initial begin
    logic       a;
    logic       r;
    logic [7:0] d;
    logic [7:0] d2;
    logic [7:0] abyte;
    int         txc;

    // reset
    rst = 1'b1; scl = 1'b1; sda_ctl = 1'b1; tx_data = 8'h00;
    repeat (5) @(negedge clk);
    check("reset_sda_oe",   {31'd0, sda_oe},   32'd0);
    check("reset_rx_data",  {24'd0, rx_data},  32'h00);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_tx_req",   {31'd0, tx_req},   32'd0);
    check("reset_busy",     {31'd0, busy},     32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // write 0xAA to 0x55
    rx_exp_q.push_back(8'hAA);
    txc = tx_req_cnt;
    bus_start();
    send_byte(8'hAA, a);
    check("t1_addr_ack", {31'd0, a}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    send_byte(8'hAA, a);
    check("t1_data_ack", {31'd0, a}, 32'd1);
    bus_stop();
    repeat (4) @(negedge clk);
    check("t1_busy_after_stop", {31'd0, busy}, 32'd0);
    check("t1_rx_data", {24'd0, rx_data}, 32'hAA);
    check("t1_no_tx_req", tx_req_cnt - txc, 32'd0);

    // read one byte 0x29, controller NACKs
    tx_data = 8'h29;
    txc = tx_req_cnt;
    bus_start();
    send_byte(8'hAB, a);
    check("t2_addr_ack", {31'd0, a}, 32'd1);
    read_byte(d, 1'b0);
    check("t2_byte", {24'd0, d}, 32'h29);
    repeat (4) @(negedge clk);
    check("t2_state_ignore", {29'd0, state_dbg}, 32'd7);
    check("t2_sda_released", {31'd0, sda_oe}, 32'd0);
    check("t2_busy_held", {31'd0, busy}, 32'd1);
    bus_stop();
    repeat (4) @(negedge clk);
    check("t2_busy_after_stop", {31'd0, busy}, 32'd0);
    check("t2_tx_req_count", tx_req_cnt - txc, 32'd1);

    // read two bytes 0x29, 0xC3
    tx_data = 8'h29;
    tx_next_q.push_back(8'hC3);
    txc = tx_req_cnt;
    bus_start();
    send_byte(8'hAB, a);
    check("t3_addr_ack", {31'd0, a}, 32'd1);
    read_byte(d, 1'b1);
    read_byte(d2, 1'b0);
    bus_stop();
    repeat (4) @(negedge clk);
    check("t3_byte0", {24'd0, d}, 32'h29);
    check("t3_byte1", {24'd0, d2}, 32'hC3);
    check("t3_tx_req_count", tx_req_cnt - txc, 32'd2);

    // address mismatch 0x12 then a data byte
    oe_seen = 1'b0;
    bus_start();
    send_byte(8'h24, a);
    check("t4_addr_nack", {31'd0, a}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_state_ignore", {29'd0, state_dbg}, 32'd7);
    send_byte(8'h77, a);
    check("t4_data_nack", {31'd0, a}, 32'd0);
    bus_stop();
    repeat (4) @(negedge clk);
    check("t4_sda_oe_never", {31'd0, oe_seen}, 32'd0);
    check("t4_rx_data_kept", {24'd0, rx_data}, 32'hAA);

    // write 0x5A, repeated START, read 0x3C
    rx_exp_q.push_back(8'h5A);
    tx_data = 8'h3C;
    txc = tx_req_cnt;
    bus_start();
    send_byte(8'hAA, a);
    check("t5_waddr_ack", {31'd0, a}, 32'd1);
    send_byte(8'h5A, a);
    check("t5_data_ack", {31'd0, a}, 32'd1);
    bus_start();
    check("t5_rx_data", {24'd0, rx_data}, 32'h5A);
    send_byte(8'hAB, a);
    check("t5_raddr_ack", {31'd0, a}, 32'd1);
    read_byte(d, 1'b0);
    check("t5_read_byte", {24'd0, d}, 32'h3C);
    bus_stop();
    repeat (4) @(negedge clk);
    check("t5_tx_req_count", tx_req_cnt - txc, 32'd1);
    check("t5_busy_after_stop", {31'd0, busy}, 32'd0);

    // reset in the address ACK slot
    abyte = 8'hAA;
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(abyte[i], r);
    wq();
    check("t6_ack_driven", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_reset_release", {31'd0, sda_oe}, 32'd0);
    check("t6_reset_busy", {31'd0, busy}, 32'd0);
    scl = 1'b1; sda_ctl = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rx_exp_q.push_back(8'h3C);
    bus_start();
    send_byte(8'hAA, a);
    check("t6_addr_ack", {31'd0, a}, 32'd1);
    send_byte(8'h3C, a);
    check("t6_data_ack", {31'd0, a}, 32'd1);
    bus_stop();
    repeat (4) @(negedge clk);
    check("t6_rx_data", {24'd0, rx_data}, 32'h3C);
    check("t6_busy_after_stop", {31'd0, busy}, 32'd0);

    check("rx_queue_drained", rx_exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
